// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN training sequencer: FSM state encoding and
// default sizing constants for block cycle, epoch length and training length.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CPC_DEF       = 18;
  localparam int NUM_CASES_DEF = 50000;
  localparam int MAX_TRAIN_DEF = 100000;
  localparam int CHUNK_W_DEF   = 8;

endpackage

// File: rtl/cycle_block_counter.sv
// Block-cycle position counter: walks 0..CPC-1 while enabled and flags the
// last cycle of each block. Held at 0 whenever disabled so every block starts
// aligned.
module cycle_block_counter #(
  parameter int CPC = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [$clog2(CPC)-1:0] cycle_index,
  output logic                   cycle_clk
);

  localparam int CW = $clog2(CPC);
  localparam logic [CW-1:0] LAST = CW'(CPC - 1);

  // Position within the block; wraps at the last cycle, cleared when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_index <= '0;
    end else if (!en) begin
      cycle_index <= '0;
    end else if (cycle_index == LAST) begin
      cycle_index <= '0;
    end else begin
      cycle_index <= cycle_index + CW'(1);
    end
  end

  assign cycle_clk = en && (cycle_index == LAST);

endmodule

// File: rtl/train_sequencer.sv
// Training sequencer: fetches training cases, runs one block cycle per case,
// prefetches the next case during the block so blocks can run back to back,
// and keeps case/epoch counters.
// Optional feature: define TRAIN_SEQ_STATS_EN to build the per-case
// mismatch tracking (tc_error / total_error); otherwise both read 0.
module train_sequencer
  import dnn_pkg::*;
#(
  parameter int CPC       = CPC_DEF,
  parameter int NUM_CASES = NUM_CASES_DEF,
  parameter int MAX_TRAIN = MAX_TRAIN_DEF,
  parameter int CHUNK_W   = CHUNK_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  output logic                         case_req,
  input  logic                         case_ack,
  output logic [$clog2(NUM_CASES)-1:0] case_idx,
  output logic [$clog2(CPC)-1:0]       cycle_index,
  output logic [$clog2(CPC-2)-1:0]     sel_network,
  output logic                         cycle_clk,
  input  logic [CHUNK_W-1:0]           a_out,
  input  logic [CHUNK_W-1:0]           y_out,
  output logic                         tc_error,
  output logic [31:0]                  total_error,
  output logic [31:0]                  num_train,
  output logic [15:0]                  epoch,
  output logic                         busy,
  output logic                         done
);

  localparam int IW  = $clog2(NUM_CASES);
  localparam int CIW = $clog2(CPC);
  localparam int SW  = $clog2(CPC-2);
  localparam logic [IW-1:0] LAST_CASE = IW'(NUM_CASES - 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  state_t state, state_nxt;
  logic   pf_ok;
  logic   stop_lat;
  logic   ack_ok;
  logic   pf_now;
  logic   last_train;
  logic   run_en;

  // A handshake only counts while a request is outstanding.
  assign ack_ok     = case_req && case_ack;
  // Prefetch is good if already latched or acked on the block's last cycle.
  assign pf_now     = pf_ok || ack_ok;
  assign last_train = (num_train == 32'(MAX_TRAIN - 1));
  assign run_en     = (state == RUN);

  cycle_block_counter #(
    .CPC(CPC)
  ) u_cycle (
    .clk        (clk),
    .reset      (reset),
    .en         (run_en),
    .cycle_index(cycle_index),
    .cycle_clk  (cycle_clk)
  );

  // Chunk select trails the cycle position by the two setup cycles; forced
  // to 0 outside RUN so idle/reset outputs read zero.
  assign sel_network = run_en ? (SW'(cycle_index) - SW'(2)) : '0;
  assign busy        = (state == FETCH) || (state == RUN);
  assign done        = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; stop outranks start and pending fetches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (stop) begin
          state_nxt = DONE;
        end else if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (stop) begin
          state_nxt = DONE;
        end else if (ack_ok) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cycle_clk) begin
          if (stop_lat || stop || last_train) begin
            state_nxt = DONE;
          end else if (pf_now) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Case request/prefetch handshake, stop latch and block-end counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      case_req  <= 1'b0;
      pf_ok     <= 1'b0;
      stop_lat  <= 1'b0;
      case_idx  <= '0;
      num_train <= '0;
      epoch     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          case_req <= start && !stop;
        end
        FETCH: begin
          if (stop || ack_ok) begin
            case_req <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            stop_lat <= 1'b1;
          end
          if (cycle_clk) begin
            // Keep requesting only if the next case still has to be fetched.
            case_req  <= (state_nxt == FETCH);
            pf_ok     <= 1'b0;
            num_train <= sat_inc32(num_train);
            if (case_idx == LAST_CASE) begin
              case_idx <= '0;
              epoch    <= sat_inc16(epoch);
            end else begin
              case_idx <= case_idx + IW'(1);
            end
          end else if (ack_ok) begin
            case_req <= 1'b0;
            pf_ok    <= 1'b1;
          end else if (!pf_ok) begin
            // Raised at cycle 0 so the prefetch request is visible from cycle 1.
            case_req <= 1'b1;
          end
        end
        default: begin
          case_req <= 1'b0;
          pf_ok    <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRAIN_SEQ_STATS_EN
  logic mism;
  assign mism = (a_out != y_out);

  // Per-case error flag (ignores the two setup cycles) and error-case count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_error    <= 1'b0;
      total_error <= '0;
    end else if (state == RUN) begin
      if (cycle_clk) begin
        if (tc_error || mism) begin
          total_error <= sat_inc32(total_error);
        end
        tc_error <= 1'b0;
      end else if ((cycle_index >= CIW'(2)) && mism) begin
        tc_error <= 1'b1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{a_out, y_out};
  assign tc_error     = 1'b0;
  assign total_error  = '0;
`endif

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer (CPC=18, NUM_CASES=4, MAX_TRAIN=10).
module tb_train_sequencer;

  localparam int CPC       = 18;
  localparam int NUM_CASES = 4;
  localparam int MAX_TRAIN = 10;
  localparam int CHUNK_W   = 8;
`ifdef TRAIN_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         case_ack = 1'b0;
  logic         case_req;
  logic [1:0]   case_idx;
  logic [4:0]   cycle_index;
  logic [3:0]   sel_network;
  logic         cycle_clk;
  logic [7:0]   a_out = 8'h00;
  logic [7:0]   y_out = 8'h00;
  logic         tc_error;
  logic [31:0]  total_error;
  logic [31:0]  num_train;
  logic [15:0]  epoch;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  bit ack_en = 1'b1;
  bit mm_en = 1'b0;
  int mm_lo = 0;
  int mm_hi = 0;
  int mm_case = -1;

  always #5 clk = ~clk;

  train_sequencer #(
    .CPC(CPC), .NUM_CASES(NUM_CASES), .MAX_TRAIN(MAX_TRAIN), .CHUNK_W(CHUNK_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .case_req(case_req), .case_ack(case_ack), .case_idx(case_idx),
    .cycle_index(cycle_index), .sel_network(sel_network), .cycle_clk(cycle_clk),
    .a_out(a_out), .y_out(y_out), .tc_error(tc_error),
    .total_error(total_error), .num_train(num_train), .epoch(epoch),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then play the case loader and DNN output.
  task automatic tick();
    @(negedge clk);
    case_ack = case_req && ack_en;
    a_out = (mm_en && busy && int'(cycle_index) >= mm_lo && int'(cycle_index) <= mm_hi &&
             (mm_case < 0 || int'(case_idx) == mm_case)) ? 8'h5A : 8'h00;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {16'b0, case_req, case_idx, cycle_index, sel_network,
                        cycle_clk, tc_error, busy, done}, 32'd0);
    chk({tag, "_cnt"}, total_error | num_train | {16'b0, epoch}, 32'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b0; start = 1'b0; stop = 1'b0; ack_en = 1'b1; mm_en = 1'b0;
    tick();
    check_zero("rst_hold");
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_pos(input int ci, input int nt, input string tag);
    logic hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      tick();
      if (busy && cycle_index == 5'(ci) && num_train == 32'(nt)) hit = 1'b1;
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_pulse(input string tag);
    logic hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      tick();
      if (cycle_clk) hit = 1'b1;
    end
    chk({tag, "_pulse"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      tick();
      if (done) hit = 1'b1;
    end
    chk({tag, "_done"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first_pulse, last, gap_bad, nt_bad;

    // Reset state and full back-to-back training run.
    reset_dut();
    check_zero("rst_after");
    start = 1'b1;
    pulses = 0; first_pulse = 0; last = 0; gap_bad = 0; nt_bad = 0;
    for (int t = 1; t <= 400 && !done; t++) begin
      tick();
      if (num_train != 32'(pulses)) nt_bad++;
      if (busy && cycle_index == 5'd5 && pulses == 0) chk("a_sel_mid", 32'(sel_network), 32'd3);
      if (cycle_clk) begin
        if (pulses == 0) begin
          first_pulse = t;
          chk("a_sel_last", 32'(sel_network), 32'd15);
        end else if (t - last != CPC) begin
          gap_bad++;
        end
        last = t;
        pulses++;
      end
    end
    chk("a_first_pulse", 32'(first_pulse), 32'd19);
    chk("a_pulses", 32'(pulses), 32'd10);
    chk("a_gaps", 32'(gap_bad), 32'd0);
    chk("a_num_train_track", 32'(nt_bad), 32'd0);
    chk("a_done", 32'(done), 32'd1);
    chk("a_num_train", num_train, 32'd10);
    chk("a_epoch", 32'(epoch), 32'd2);
    chk("a_case_idx", 32'(case_idx), 32'd2);
    chk("a_total_error", total_error, 32'd0);
    chk("a_idle_outs", {29'b0, busy, case_req, cycle_clk}, 32'd0);
    repeat (5) tick();
    chk("a_done_sticky", 32'(done), 32'd1);
    chk("a_num_train_hold", num_train, 32'd10);

    // Mismatch at cycle 5 of case 1 only.
    reset_dut();
    mm_en = 1'b1; mm_lo = 5; mm_hi = 5; mm_case = 1;
    start = 1'b1;
    wait_pos(6, 0, "b_case0");
    chk("b_case0_clean", 32'(tc_error), 32'd0);
    wait_pos(5, 1, "b_case1");
    chk("b_before", 32'(tc_error), 32'd0);
    tick();
    chk("b_set_idx", 32'(cycle_index), 32'd6);
    chk("b_set", 32'(tc_error), 32'(STATS));
    wait_pulse("b_end");
    chk("b_te_pre", total_error, 32'd0);
    tick();
    chk("b_te_post", total_error, 32'(STATS));
    chk("b_tc_clear", 32'(tc_error), 32'd0);
    wait_pos(10, 2, "b_next");
    chk("b_next_clean", 32'(tc_error), 32'd0);
    chk("b_te_hold", total_error, 32'(STATS));

    // Mismatch only in the setup cycles, then only on the last cycle.
    reset_dut();
    mm_en = 1'b1; mm_lo = 0; mm_hi = 1; mm_case = -1;
    start = 1'b1;
    wait_pos(10, 2, "c_setup");
    chk("c_setup_te", total_error, 32'd0);
    chk("c_setup_tc", 32'(tc_error), 32'd0);
    mm_lo = 17; mm_hi = 17;
    wait_pulse("c_last");
    tick();
    chk("c_last_te", total_error, 32'(STATS));
    chk("c_last_tc", 32'(tc_error), 32'd0);

    // Slow loader: 30-clock FETCH gap between blocks.
    reset_dut();
    start = 1'b1;
    tick();
    chk("d_fetch", {30'b0, busy, case_req}, 32'd3);
    ack_en = 1'b0;
    wait_pulse("d_blk0");
    gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cycle_index != 5'd0 || cycle_clk || !busy || !case_req) gap_bad++;
      if (i == 28) ack_en = 1'b1;
    end
    chk("d_gap", 32'(gap_bad), 32'd0);
    chk("d_gap_count", num_train, 32'd1);
    tick();
    chk("d_resume", {27'b0, cycle_index}, 32'd0);
    chk("d_resume_req", 32'(case_req), 32'd0);
    tick();
    chk("d_resume_run", {27'b0, cycle_index}, 32'd1);
    chk("d_case_idx", 32'(case_idx), 32'd1);

    // Stop mid-block 3: the block finishes first.
    reset_dut();
    start = 1'b1;
    wait_pos(7, 2, "e_blk3");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("e_continues", {26'b0, busy, cycle_index}, {26'b0, 1'b1, 5'd8});
    wait_done("e_stop");
    chk("e_num_train", num_train, 32'd3);
    chk("e_case_idx", 32'(case_idx), 32'd3);
    chk("e_req_low", 32'(case_req), 32'd0);

    // Stop while idle, and while waiting for a case.
    reset_dut();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("e_stop_idle", {30'b0, busy, done}, 32'd1);
    reset_dut();
    ack_en = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("e_fetch_wait", {30'b0, busy, case_req}, 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("e_stop_fetch", {29'b0, busy, case_req, done}, 32'd1);

    // Asynchronous reset in the middle of a block, then restart.
    reset_dut();
    start = 1'b1;
    wait_pos(9, 1, "f_mid");
    chk("f_mid_idx", 32'(case_idx), 32'd1);
    reset = 1'b0;
    #1;
    check_zero("f_async");
    tick();
    check_zero("f_held");
    reset = 1'b1;
    wait_pos(3, 0, "f_restart");
    chk("f_restart_idx", 32'(case_idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
